// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the SYNC_FIFO read-side master: default data width,
// output-buffer sizing and the small arithmetic helpers used by the issue rule
// and the buffer occupancy update.
package sync_fifo_pkg;

  localparam int DEF_DWIDTH = 4;
  localparam int OCC_W      = 2;
  localparam int BUF_DEPTH  = 2;

  typedef logic [OCC_W-1:0] occ_t;

  // Occupancy after one clock with an optional push and an optional pop.
  function automatic occ_t occ_update(occ_t occ, logic push, logic pop);
    return occ + {1'b0, push} - {1'b0, pop};
  endfunction

  // A new FIFO read may be issued only if the words already held plus the
  // word still arriving, minus the word leaving this cycle, leave a free slot.
  function automatic logic may_issue(occ_t occ, logic inflight, logic pop);
    logic [OCC_W:0] sum_s;
    sum_s = {1'b0, occ} + {{OCC_W{1'b0}}, inflight} - {{OCC_W{1'b0}}, pop};
    return (sum_s < (OCC_W + 1)'(BUF_DEPTH));
  endfunction

endpackage

// File: rtl/sync_fifo_reader_if.sv
// Bundles the FIFO read port and the downstream valid/ready stream seen by
// sync_fifo_reader. The master modport is the reader's view; the slave
// modport is the view of the environment (FIFO plus stream consumer).
interface sync_fifo_reader_if #(
  parameter int DWIDTH = 4
);

  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [DWIDTH-1:0] fifo_rd_data;
  logic              m_valid;
  logic              m_ready;
  logic [DWIDTH-1:0] m_data;

  modport master (
    input  fifo_empty,
    input  fifo_rd_data,
    input  m_ready,
    output fifo_rd_en,
    output m_valid,
    output m_data
  );

  modport slave (
    output fifo_empty,
    output fifo_rd_data,
    output m_ready,
    input  fifo_rd_en,
    input  m_valid,
    input  m_data
  );

endinterface

// File: rtl/sync_fifo_reader_chk.sv
// Safety properties for the FIFO reader: the output buffer never overfills,
// a word never arrives into a full buffer that is not draining, and the FIFO
// is never read while it reports empty.
module sync_fifo_reader_chk
  import sync_fifo_pkg::*;
(
  input logic clk,
  input logic rst,
  input occ_t occ,
  input logic inflight,
  input logic full,
  input logic pop,
  input logic rd_en,
  input logic fifo_empty
);

  a_occ_max: assert property (@(posedge clk) disable iff (rst)
    occ <= occ_t'(BUF_DEPTH));

  a_no_overfill: assert property (@(posedge clk) disable iff (rst)
    !(inflight && full && !pop));

  a_no_empty_read: assert property (@(posedge clk) disable iff (rst)
    !(rd_en && fifo_empty));

endmodule

// File: rtl/sync_fifo_reader_skid.sv
// Two-entry output buffer for the FIFO reader. Words are written at the write
// index and presented from the read index; both indices are one bit wide and
// simply toggle. Storage clears on reset so the head word reads as zero.
module fifo_rd_skid
  import sync_fifo_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              pop,
  output occ_t              occ,
  output logic              full,
  output logic              empty,
  output logic [DWIDTH-1:0] head_data
);

  logic [DWIDTH-1:0] mem_r [BUF_DEPTH];
  logic              wr_idx_r;
  logic              rd_idx_r;
  occ_t              occ_r;

  // Buffer storage, index toggling and occupancy tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_idx_r <= 1'b0;
      rd_idx_r <= 1'b0;
      occ_r    <= '0;
    end else begin
      if (push) begin
        mem_r[wr_idx_r] <= push_data;
        wr_idx_r        <= ~wr_idx_r;
      end
      if (pop) begin
        rd_idx_r <= ~rd_idx_r;
      end
      occ_r <= occ_update(occ_r, push, pop);
    end
  end

  assign occ       = occ_r;
  assign full      = (occ_r == occ_t'(BUF_DEPTH));
  assign empty     = (occ_r == 2'd0);
  assign head_data = mem_r[rd_idx_r];

endmodule

// File: rtl/sync_fifo_reader.sv
// Read-side master for SYNC_FIFO. Issues rd_en only when the FIFO has data and
// the output buffer is guaranteed a slot for the word one cycle later, then
// re-presents captured words as a valid/ready stream. No bypass path exists
// from the FIFO data to m_data, so read-to-output latency is two cycles.
module sync_fifo_reader
  import sync_fifo_pkg::*;
#(
  parameter int DWIDTH    = DEF_DWIDTH,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  sync_fifo_reader_if.master   bus,
  output logic [CNT_WIDTH-1:0] word_cnt,
  output logic                 busy
);

  logic                 inflight_r;
  logic [CNT_WIDTH-1:0] word_cnt_r;
  logic                 pop_s;
  logic                 rd_en_s;
  logic                 full_s;
  logic                 empty_s;
  occ_t                 occ_s;
  logic [DWIDTH-1:0]    head_s;

  assign pop_s = ~empty_s & bus.m_ready;

  // Issue rule: read only from a non-empty FIFO, with buffer space reserved, never in reset.
  always_comb begin
    rd_en_s = 1'b0;
    if (rst) begin
      rd_en_s = 1'b0;
    end else begin
      rd_en_s = ~bus.fifo_empty & may_issue(occ_s, inflight_r, pop_s);
    end
  end

  // In-flight flag (FIFO data valid next cycle) and delivered-word counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_r <= 1'b0;
      word_cnt_r <= '0;
    end else begin
      inflight_r <= rd_en_s;
      if (pop_s) begin
        word_cnt_r <= word_cnt_r + CNT_WIDTH'(1);
      end
    end
  end

  fifo_rd_skid #(
    .DWIDTH (DWIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_r),
    .push_data (bus.fifo_rd_data),
    .pop       (pop_s),
    .occ       (occ_s),
    .full      (full_s),
    .empty     (empty_s),
    .head_data (head_s)
  );

  sync_fifo_reader_chk u_chk (
    .clk        (clk),
    .rst        (rst),
    .occ        (occ_s),
    .inflight   (inflight_r),
    .full       (full_s),
    .pop        (pop_s),
    .rd_en      (rd_en_s),
    .fifo_empty (bus.fifo_empty)
  );

  assign bus.fifo_rd_en = rd_en_s;
  assign bus.m_valid    = ~empty_s;
  assign bus.m_data     = head_s;
  assign word_cnt       = word_cnt_r;
  assign busy           = ~empty_s | inflight_r;

endmodule

// File: tb/tb_sync_fifo_reader.sv
// Bench for sync_fifo_reader: a behavioural 4-deep sync FIFO feeds the DUT,
// words accepted by the FIFO are queued as expectations, and an independent
// monitor pops and compares every stream handshake.
module tb_sync_fifo_reader;

  localparam int DW = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_rst;
  logic          wr_en;
  logic [DW-1:0] wdata;
  logic [CW-1:0] word_cnt;
  logic          busy;

  sync_fifo_reader_if #(.DWIDTH(DW)) bus ();

  sync_fifo_reader #(
    .DWIDTH    (DW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .word_cnt (word_cnt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  logic [DW-1:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural FIFO (depth 4, registered read data) -------
  logic [DW-1:0] fmem [4];
  logic [2:0]    fcnt;
  logic [1:0]    fwp, frp;
  int            underflow_cnt = 0;
  logic          wr_ok_s, rd_ok_s;

  assign bus.fifo_empty = (fcnt == 3'd0);
  assign wr_ok_s = wr_en && (fcnt < 3'd4);
  assign rd_ok_s = bus.fifo_rd_en && (fcnt != 3'd0);

  always @(posedge clk or posedge fifo_rst) begin
    if (fifo_rst) begin
      fcnt <= 3'd0;
      fwp  <= 2'd0;
      frp  <= 2'd0;
      bus.fifo_rd_data <= '0;
    end else begin
      if (bus.fifo_rd_en && fcnt == 3'd0) underflow_cnt <= underflow_cnt + 1;
      if (wr_ok_s) begin
        fmem[fwp] <= wdata;
        fwp <= fwp + 2'd1;
      end
      if (rd_ok_s) begin
        bus.fifo_rd_data <= fmem[frp];
        frp <= frp + 2'd1;
      end
      fcnt <= fcnt + {2'b0, wr_ok_s} - {2'b0, rd_ok_s};
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [CW-1:0] exp_cnt;
    logic          hold_prev;
    logic [DW-1:0] hold_data;
    logic [DW-1:0] exp_w;
    exp_cnt = '0;
    hold_prev = 1'b0;
    hold_data = '0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        exp_cnt = '0;
        hold_prev = 1'b0;
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_word_cnt", word_cnt, 0);
      end else begin
        if (hold_prev) check("hold_stable", {bus.m_valid, bus.m_data}, {1'b1, hold_data});
        if (bus.m_valid && bus.m_ready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL sb_spurious: got word %0h expected none at %0t", bus.m_data, $time);
          end else begin
            exp_w = exp_q.pop_front();
            check("sb_data", bus.m_data, exp_w);
          end
          check("sb_word_cnt", word_cnt, exp_cnt);
          exp_cnt = exp_cnt + 3'd1;
        end
        hold_prev = bus.m_valid && !bus.m_ready;
        hold_data = bus.m_data;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_write(input logic [DW-1:0] d);
    wr_en = 1'b1;
    wdata = d;
    if (fcnt < 3'd4 && !fifo_rst) exp_q.push_back(d);
  endtask

  task automatic reset_all();
    rst = 1'b1;
    fifo_rst = 1'b1;
    wr_en = 1'b0;
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b0;
    fifo_rst = 1'b0;
  endtask

  task automatic drain(input bit alt);
    bit done;
    done = 1'b0;
    wr_en = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (exp_q.size() == 0 && !busy && fcnt == 3'd0) begin
        done = 1'b1;
      end else begin
        bus.m_ready = alt ? ~bus.m_ready : 1'b1;
        tick();
      end
    end
    check("drain_done", done, 1);
    bus.m_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed tests ----------------
  initial begin
    logic [9:0] rd_pat, vld_pat;
    int rd_n, idx;

    rst = 1'b1;
    fifo_rst = 1'b1;
    wr_en = 1'b0;
    wdata = '0;
    bus.m_ready = 1'b1;
    tick();

    // 1. reset held while FIFO holds data
    fifo_rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c < 2) drive_write(DW'(4'hA + c)); else wr_en = 1'b0;
      @(negedge clk);
      check("rst_rd_en", bus.fifo_rd_en, 0);
      tick();
    end
    rst = 1'b0;
    @(negedge clk);
    check("first_rd_en", bus.fifo_rd_en, 1);
    tick();
    drain(1'b0);

    // 2. streaming 1..4
    reset_all();
    rd_pat = '0;
    vld_pat = '0;
    for (int c = 0; c < 10; c++) begin
      if (c < 4) drive_write(DW'(c + 1)); else wr_en = 1'b0;
      @(negedge clk);
      rd_pat[c]  = bus.fifo_rd_en;
      vld_pat[c] = bus.m_valid;
      tick();
    end
    check("stream_rd_en", rd_pat, 10'b00_0001_1110);
    check("stream_valid", vld_pat, 10'b00_0111_1000);
    @(negedge clk);
    check("stream_busy", busy, 0);
    check("stream_cnt", word_cnt, 4);
    tick();

    // 3. backpressure with A,B,C,D
    reset_all();
    bus.m_ready = 1'b0;
    rd_n = 0;
    for (int c = 0; c < 9; c++) begin
      if (c < 4) drive_write(DW'(4'hA + c)); else wr_en = 1'b0;
      @(negedge clk);
      rd_n += int'(bus.fifo_rd_en);
      if (c >= 3) check("bp_head", {bus.m_valid, bus.m_data}, {1'b1, 4'hA});
      tick();
    end
    check("bp_reads", rd_n, 2);
    check("bp_fifo_left", fcnt, 2);
    drain(1'b0);

    // 4. alternating m_ready with continuous writes 0..15
    reset_all();
    idx = 0;
    for (int c = 0; c < 200 && idx < 16; c++) begin
      bus.m_ready = (c % 2 == 0);
      if (fcnt < 3'd4) begin
        drive_write(DW'(idx));
        idx++;
      end else begin
        wr_en = 1'b0;
      end
      tick();
    end
    check("alt_all_written", idx, 16);
    drain(1'b1);

    // 5. counter wrap: 9 words into a 3-bit counter
    reset_all();
    idx = 1;
    for (int c = 0; c < 100 && idx <= 9; c++) begin
      if (fcnt < 3'd4) begin
        drive_write(DW'(idx));
        idx++;
      end else begin
        wr_en = 1'b0;
      end
      tick();
    end
    drain(1'b0);
    check("cnt_wrap", word_cnt, 1);

    // 6. reset mid-stream
    reset_all();
    for (int c = 0; c < 4; c++) begin
      drive_write(DW'(c + 5));
      @(negedge clk);
      if (c == 1) check("mid_rd_en", bus.fifo_rd_en, 1);
      if (c == 3) check("mid_valid", {bus.m_valid, bus.m_data}, {1'b1, 4'h5});
      tick();
    end
    check("pre_rst_valid", bus.m_valid, 1);
    wr_en = 1'b0;
    rst = 1'b1;
    fifo_rst = 1'b1;
    exp_q.delete();
    #1;
    check("rst_async", {bus.m_valid, bus.fifo_rd_en, busy}, 3'b000);
    repeat (2) tick();
    rst = 1'b0;
    fifo_rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("no_stale", {bus.m_valid, bus.m_data, bus.fifo_rd_en}, 0);
      tick();
    end
    drive_write(4'h9);
    tick();
    drive_write(4'hA);
    tick();
    drain(1'b0);
    check("post_rst_cnt", word_cnt, 2);

    check("no_underflow", underflow_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
